// File: rtl/motor_mixer_n_pkg.sv
// Shared types and defaults for the time-multiplexed motor mixer.
// Fixed-point defaults use 4 fractional bits (16 = 1.0, 4080 = 255.0).
package motor_mixer_n_pkg;

  localparam int DEF_NUM_MOTORS  = 4;
  localparam int DEF_RATE_WIDTH  = 16;
  localparam int DEF_FRAC_BITS   = 4;
  localparam int DEF_MOTOR_WIDTH = 8;
  localparam int DEF_MOTOR_MIN   = 16;
  localparam int DEF_MOTOR_MAX   = 4080;

  // Bit i set subtracts the axis for motor i+1; sized for the 8-motor maximum.
  localparam logic [7:0] DEF_YAW_NEG   = 8'b0000_0101;
  localparam logic [7:0] DEF_ROLL_NEG  = 8'b0000_0110;
  localparam logic [7:0] DEF_PITCH_NEG = 8'b0000_1100;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCALE  = 2'd1,
    ST_MIX    = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

endpackage

// File: rtl/motor_mix_lane.sv
// Combinational per-motor mix: signed sum, arming gate, clamp and slew.
// One instance is time-shared across all motors by the top-level index.
module motor_mix_lane #(
  parameter int RATE_WIDTH  = 16,
  parameter int FRAC_BITS   = 4,
  parameter int MOTOR_WIDTH = 8,
  parameter int BIAS        = 0,
  parameter int MOTOR_MIN   = 16,
  parameter int MOTOR_MAX   = 4080,
  parameter int SLEW_STEP   = 0
) (
  input  logic signed [RATE_WIDTH-1:0] throttle,
  input  logic signed [RATE_WIDTH-1:0] yaw_s,
  input  logic signed [RATE_WIDTH-1:0] roll_s,
  input  logic signed [RATE_WIDTH-1:0] pitch_s,
  input  logic                         yaw_neg,
  input  logic                         roll_neg,
  input  logic                         pitch_neg,
  input  logic                         armed,
  input  logic        [MOTOR_WIDTH-1:0] prev,
  output logic        [MOTOR_WIDTH-1:0] rate
);

  // Three guard bits: four operands plus bias can never wrap.
  localparam int SW = RATE_WIDTH + 3;
  localparam logic signed [SW-1:0]      MIN_S  = SW'(MOTOR_MIN);
  localparam logic signed [SW-1:0]      MAX_S  = SW'(MOTOR_MAX);
  localparam logic signed [SW-1:0]      BIAS_S = SW'(BIAS);
  localparam logic [MOTOR_WIDTH-1:0]    STEP   = MOTOR_WIDTH'(SLEW_STEP);

  logic signed [SW-1:0]   thr_x, yaw_x, roll_x, pitch_x, sum, clamped;
  logic [MOTOR_WIDTH-1:0] target, delta;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    thr_x   = SW'(throttle);
    yaw_x   = SW'(yaw_s);
    roll_x  = SW'(roll_s);
    pitch_x = SW'(pitch_s);

    sum = BIAS_S + thr_x;
    sum = yaw_neg   ? sum - yaw_x   : sum + yaw_x;
    sum = roll_neg  ? sum - roll_x  : sum + roll_x;
    sum = pitch_neg ? sum - pitch_x : sum + pitch_x;

    if (sum < MIN_S)      clamped = MIN_S;
    else if (sum > MAX_S) clamped = MAX_S;
    else                  clamped = sum;

    target = MOTOR_WIDTH'(clamped >>> FRAC_BITS);
    if (!armed || thr_x <= MIN_S) target = '0;

    // A zero target bypasses the slew limiter so a cut is immediate.
    rate  = target;
    delta = '0;
    if (SLEW_STEP != 0 && target != '0) begin
      if (target > prev) begin
        delta = target - prev;
        rate  = prev + ((delta > STEP) ? STEP : delta);
      end else begin
        delta = prev - target;
        rate  = prev - ((delta > STEP) ? STEP : delta);
      end
    end
  end

endmodule

// File: rtl/motor_mixer_n.sv
// Time-multiplexed mixer: accepts one rate command, scales the axes, then
// mixes one motor per cycle through a shared lane and strobes out_valid.
module motor_mixer_n
  import motor_mixer_n_pkg::*;
#(
  parameter int         NUM_MOTORS  = DEF_NUM_MOTORS,
  parameter int         RATE_WIDTH  = DEF_RATE_WIDTH,
  parameter int         FRAC_BITS   = DEF_FRAC_BITS,
  parameter int         MOTOR_WIDTH = DEF_MOTOR_WIDTH,
  parameter logic [7:0] YAW_NEG     = DEF_YAW_NEG,
  parameter logic [7:0] ROLL_NEG    = DEF_ROLL_NEG,
  parameter logic [7:0] PITCH_NEG   = DEF_PITCH_NEG,
  parameter int         YAW_SHIFT   = 1,
  parameter int         ROLL_SHIFT  = 1,
  parameter int         PITCH_SHIFT = 1,
  parameter int         BIAS        = 0,
  parameter int         MOTOR_MIN   = DEF_MOTOR_MIN,
  parameter int         MOTOR_MAX   = DEF_MOTOR_MAX,
  parameter int         SLEW_STEP   = 0
) (
  input  logic                                 sys_clk,
  input  logic                                 resetn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [RATE_WIDTH-1:0]         yaw_rate,
  input  logic signed [RATE_WIDTH-1:0]         roll_rate,
  input  logic signed [RATE_WIDTH-1:0]         pitch_rate,
  input  logic signed [RATE_WIDTH-1:0]         throttle_rate,
  input  logic                                 armed,
  output logic [NUM_MOTORS*MOTOR_WIDTH-1:0]    motor_rates,
  output logic                                 out_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOTORS - 1);

  state_e state_q, state_d;

  logic signed [RATE_WIDTH-1:0] thr_q, thr_d;
  logic signed [RATE_WIDTH-1:0] yaw_q, yaw_d;
  logic signed [RATE_WIDTH-1:0] roll_q, roll_d;
  logic signed [RATE_WIDTH-1:0] pitch_q, pitch_d;
  logic                         armed_q, armed_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [MOTOR_WIDTH-1:0]       motor_q [NUM_MOTORS];
  logic [MOTOR_WIDTH-1:0]       motor_d [NUM_MOTORS];
  logic [MOTOR_WIDTH-1:0]       prev_rate, lane_rate;
  logic                         accept;

  assign accept = in_ready && in_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SCALE;
      ST_SCALE:  state_d = ST_MIX;
      ST_MIX:    if (idx_q == LAST_IDX) state_d = ST_OUTPUT;
      ST_OUTPUT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUTPUT);
  end

  always_comb begin
    thr_d   = thr_q;
    yaw_d   = yaw_q;
    roll_d  = roll_q;
    pitch_d = pitch_q;
    armed_d = armed_q;
    idx_d   = idx_q;
    motor_d = motor_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          thr_d   = throttle_rate;
          yaw_d   = yaw_rate;
          roll_d  = roll_rate;
          pitch_d = pitch_rate;
          armed_d = armed;
        end
      end
      ST_SCALE: begin
        yaw_d   = yaw_q   >>> YAW_SHIFT;
        roll_d  = roll_q  >>> ROLL_SHIFT;
        pitch_d = pitch_q >>> PITCH_SHIFT;
        idx_d   = '0;
      end
      ST_MIX: begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
          if (idx_q == IDX_W'(i)) motor_d[i] = lane_rate;
        end
        idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Previous value of the slot being mixed feeds the slew limiter.
  always_comb begin
    prev_rate = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (idx_q == IDX_W'(i)) prev_rate = motor_q[i];
    end
  end

  motor_mix_lane #(
    .RATE_WIDTH  (RATE_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .MOTOR_WIDTH (MOTOR_WIDTH),
    .BIAS        (BIAS),
    .MOTOR_MIN   (MOTOR_MIN),
    .MOTOR_MAX   (MOTOR_MAX),
    .SLEW_STEP   (SLEW_STEP)
  ) u_lane (
    .throttle  (thr_q),
    .yaw_s     (yaw_q),
    .roll_s    (roll_q),
    .pitch_s   (pitch_q),
    .yaw_neg   (YAW_NEG[idx_q]),
    .roll_neg  (ROLL_NEG[idx_q]),
    .pitch_neg (PITCH_NEG[idx_q]),
    .armed     (armed_q),
    .prev      (prev_rate),
    .rate      (lane_rate)
  );

  // NOTE: the motor slot array is a handful of flops driving outputs, so it is reset like any other register.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      thr_q   <= '0;
      yaw_q   <= '0;
      roll_q  <= '0;
      pitch_q <= '0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) motor_q[i] <= '0;
    end else begin
      thr_q   <= thr_d;
      yaw_q   <= yaw_d;
      roll_q  <= roll_d;
      pitch_q <= pitch_d;
      armed_q <= armed_d;
      idx_q   <= idx_d;
      motor_q <= motor_d;
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_out
    assign motor_rates[g*MOTOR_WIDTH +: MOTOR_WIDTH] = motor_q[g];
  end

endmodule

// File: tb/tb_motor_mixer_n.sv
// Scoreboard bench: two mixers (slew off / slew 5) share stimulus; a
// behavioural model predicts each update and a monitor checks on out_valid.
module tb_motor_mixer_n;

  localparam int NM  = 4;
  localparam int LAT = NM + 2;
  localparam int YN  = 4'b0101;
  localparam int RN  = 4'b0110;
  localparam int PN  = 4'b1100;

  logic sys_clk = 1'b0;
  logic resetn  = 1'b0;
  logic in_valid = 1'b0;
  logic armed    = 1'b0;
  logic signed [15:0] yaw_rate = '0, roll_rate = '0, pitch_rate = '0, throttle_rate = '0;

  logic        rdy_a, rdy_b, ov_a, ov_b;
  logic [31:0] rates_a, rates_b;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] rates;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   prev_m[2][NM];

  motor_mixer_n dut_a (
    .sys_clk(sys_clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_a),
    .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
    .throttle_rate(throttle_rate), .armed(armed), .motor_rates(rates_a), .out_valid(ov_a)
  );

  motor_mixer_n #(.SLEW_STEP(5)) dut_b (
    .sys_clk(sys_clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_b),
    .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
    .throttle_rate(throttle_rate), .armed(armed), .motor_rates(rates_b), .out_valid(ov_b)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: motor value from the mixing rules in plain integer arithmetic.
  function automatic int mix_one(int thr, int y, int r, int p, bit arm, int m, int prev, int step);
    int s, t;
    s = thr;
    s += ((YN >> m) & 1) ? -(y >>> 1) : (y >>> 1);
    s += ((RN >> m) & 1) ? -(r >>> 1) : (r >>> 1);
    s += ((PN >> m) & 1) ? -(p >>> 1) : (p >>> 1);
    if (!arm || thr <= 16) return 0;
    if (s < 16)   s = 16;
    if (s > 4080) s = 4080;
    t = s / 16;
    if (step == 0)         return t;
    if (t - prev > step)   return prev + step;
    if (prev - t > step)   return prev - step;
    return t;
  endfunction

  task automatic send(input logic signed [15:0] thr, input logic signed [15:0] y,
                      input logic signed [15:0] r, input logic signed [15:0] p,
                      input bit arm, input bit hold, output int t_acc);
    int   waitc;
    int   nv;
    exp_t e;
    waitc = 0;
    @(negedge sys_clk);
    throttle_rate = thr; yaw_rate = y; roll_rate = r; pitch_rate = p;
    armed = arm; in_valid = 1'b1;
    while (!rdy_a && waitc < 50) begin
      @(negedge sys_clk);
      waitc++;
    end
    if (!rdy_a) begin
      check("ready_timeout", 32'(rdy_a), 32'd1);
      in_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc;
    for (int k = 0; k < 2; k++) begin
      e.rates = '0;
      e.due   = t_acc + LAT;
      for (int m = 0; m < NM; m++) begin
        nv = mix_one(thr, y, r, p, arm, m, prev_m[k][m], (k == 0) ? 0 : 5);
        prev_m[k][m] = nv;
        e.rates[m*8 +: 8] = 8'(nv);
      end
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge sys_clk);
    check("busy_in_ready", 32'(rdy_a), 32'd0);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check("out_valid_timeout", 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic mon(input int k, input logic [31:0] act);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check($sformatf("unexpected_out_valid%0d", k), 32'd1, 32'd0);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("rates_dut%0d", k), act, e.rates);
    check($sformatf("latency_dut%0d", k), 32'(cyc), 32'(e.due));
  endtask

  always @(negedge sys_clk) begin
    if (resetn) begin
      if (ov_a) mon(0, rates_a);
      if (ov_b) mon(1, rates_b);
    end
  end

  initial begin
    int ta, t0, t1, t2;
    logic signed [15:0] rt, ry, rr, rp;

    repeat (3) @(negedge sys_clk);
    check("reset_rates_a", rates_a, 32'h0);
    check("reset_rates_b", rates_b, 32'h0);
    check("reset_in_ready", 32'(rdy_a), 32'd1);
    check("reset_out_valid", 32'(ov_a), 32'd0);
    resetn = 1'b1;

    // Hover, roll, saturation, large negative yaw.
    send(16'sh0640, 16'sh0, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    wait_done();
    check("hover_a", rates_a, 32'h6464_6464);
    send(16'sh0640, 16'sh0, 16'sh0140, 16'sh0, 1'b1, 1'b0, ta);
    wait_done();
    check("roll_a", rates_a, 32'h6E5A_5A6E);
    send(16'sh1000, 16'sh0, 16'sh0, 16'sh0200, 1'b1, 1'b0, ta);
    send(16'sh0640, 16'shC000, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    wait_done();
    check("yaw_clamp_a", rates_a, 32'h01FF_01FF);

    // Gate: disarmed, then throttle below MOTOR_MIN.
    send(16'sh0800, 16'sh0300, 16'sh0200, 16'sh0100, 1'b0, 1'b0, ta);
    wait_done();
    check("disarm_a", rates_a, 32'h0);
    check("disarm_b", rates_b, 32'h0);
    send(16'sh0008, 16'sh0300, 16'sh0200, 16'sh0100, 1'b1, 1'b0, ta);
    wait_done();
    check("low_throttle_a", rates_a, 32'h0);

    // Inputs changing mid-update are ignored.
    send(16'sh0640, 16'sh0080, 16'sh0040, 16'sh0020, 1'b1, 1'b0, ta);
    armed = 1'b0; throttle_rate = 16'sh0; yaw_rate = 16'sh7000;
    repeat (4) @(negedge sys_clk);
    armed = 1'b1;
    wait_done();

    // Back-to-back with in_valid held high.
    send(16'sh0500, 16'sh0010, 16'sh0, 16'sh0, 1'b1, 1'b1, t0);
    send(16'sh0600, 16'sh0, 16'sh0020, 16'sh0, 1'b1, 1'b1, t1);
    send(16'sh0700, 16'sh0, 16'sh0, 16'sh0030, 1'b1, 1'b0, t2);
    check("b2b_gap1", 32'(t1 - t0), 32'(NM + 3));
    check("b2b_gap2", 32'(t2 - t1), 32'(NM + 3));
    wait_done();

    // Reset in the middle of MIX abandons the update.
    send(16'sh0900, 16'sh0100, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    repeat (2) @(negedge sys_clk);
    resetn = 1'b0;
    #1;
    check("midmix_reset_rates_a", rates_a, 32'h0);
    check("midmix_reset_rates_b", rates_b, 32'h0);
    check("midmix_reset_in_ready", 32'(rdy_a), 32'd1);
    check("midmix_reset_out_valid", 32'(ov_b), 32'd0);
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < NM; m++) prev_m[k][m] = 0;
    @(negedge sys_clk);
    resetn = 1'b1;

    // Slew: ramp the limited mixer to 100, then command 150 three times.
    for (int i = 0; i < 20; i++) send(16'sh0640, 16'sh0, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    wait_done();
    check("slew_reach_100", rates_b, 32'h6464_6464);
    send(16'sh0960, 16'sh0, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    wait_done();
    check("slew_105", 32'(rates_b[7:0]), 32'd105);
    send(16'sh0960, 16'sh0, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    send(16'sh0960, 16'sh0, 16'sh0, 16'sh0, 1'b1, 1'b0, ta);
    wait_done();
    check("slew_115", rates_b, 32'h7373_7373);
    send(16'sh0960, 16'sh0, 16'sh0, 16'sh0, 1'b0, 1'b0, ta);
    wait_done();
    check("slew_cut", rates_b, 32'h0);

    // Randomised commands against the model.
    for (int i = 0; i < 40; i++) begin
      rt = 16'($urandom_range(0, 16'h1400));
      if ($urandom_range(0, 7) == 0) rt = 16'($urandom);
      ry = 16'($urandom);
      rr = 16'($urandom_range(0, 16'h0800)) - 16'sh0400;
      rp = 16'($urandom_range(0, 16'h0800)) - 16'sh0400;
      send(rt, ry, rr, rp, ($urandom_range(0, 4) != 0),
           (i < 39) && ($urandom_range(0, 1) == 1), ta);
    end
    wait_done();

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
